// File: rtl/sobel_pkg.sv
// Shared constants and types for the Sobel edge-detection path.
package sobel_pkg;

  localparam int H_ACTIVE      = 512;
  localparam int V_ACTIVE      = 384;
  localparam int SOBEL_LATENCY = 3;
  localparam int EDGE_CNT_W    = $clog2(H_ACTIVE * V_ACTIVE + 1);
  localparam int COORD_W       = 11;
  localparam int PIX_W         = 24;

  typedef enum logic [1:0] {
    GRAY    = 2'd0,
    BINARY  = 2'd1,
    OVERLAY = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    ACTIVE   = 2'd1,
    EOF      = 2'd2
  } cnt_state_t;

endpackage

// File: rtl/coord_delay.sv
// Fixed-depth shift register. Only the valid bit is reset, so a zeroed
// payload coming out of reset is never mistaken for a real pixel.
module coord_delay #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 46
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             vld,
  input  logic [WIDTH-1:0] data,
  output logic             dly_vld,
  output logic [WIDTH-1:0] dly_data
);

  logic [DEPTH-1:0] vld_pipe;
  logic [WIDTH-1:0] data_pipe [DEPTH];

  // valid bits shift through the line and clear on reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= vld;
      for (int i = 1; i < DEPTH; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  // payload shifts alongside the valid bits without reset
  always_ff @(posedge clock) begin
    data_pipe[0] <= data;
    for (int i = 1; i < DEPTH; i++) data_pipe[i] <= data_pipe[i-1];
  end

  assign dly_vld  = vld_pipe[DEPTH-1];
  assign dly_data = data_pipe[DEPTH-1];

endmodule

// File: rtl/sobel_post.sv
// Sobel post-processing: realigns the magnitude with its coordinates and
// RGB pixel, masks the 2-pixel border, thresholds, and builds the display
// pixel (gray / binary / overlay). Define SOBEL_EDGE_COUNT_EN to add the
// per-frame edge counter (edge_count / count_valid ports).
module sobel_post
  import sobel_pkg::*;
#(
  parameter int          WORD_SIZE  = 8,
  parameter int          H_ACTIVE   = sobel_pkg::H_ACTIVE,
  parameter int          V_ACTIVE   = sobel_pkg::V_ACTIVE,
  parameter int          LATENCY    = SOBEL_LATENCY,
  parameter logic [23:0] EDGE_COLOR = 24'hFF0000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [10:0]          hc_visible,
  input  logic [10:0]          vc_visible,
  input  logic [23:0]          pixel_in,
  input  logic [WORD_SIZE-1:0] edge_in,
  input  logic [WORD_SIZE-1:0] threshold,
  input  logic [1:0]           mode,
  output logic [23:0]          pixel_out,
  output logic                 pixel_valid
`ifdef SOBEL_EDGE_COUNT_EN
  ,
  output logic [$clog2(H_ACTIVE*V_ACTIVE+1)-1:0] edge_count,
  output logic                                   count_valid
`endif
);

  localparam int DLY_W = 2 * COORD_W + PIX_W;

  // Gray output replicates the top 8 magnitude bits on R, G and B.
  function automatic logic [23:0] gray_pix(input logic [WORD_SIZE-1:0] m);
    return {3{m[WORD_SIZE-1 -: 8]}};
  endfunction

  logic                 vis;
  logic                 dvis_p0;
  logic [COORD_W-1:0]   dh_p0;
  logic [COORD_W-1:0]   dv_p0;
  logic [PIX_W-1:0]     dpix_p0;
  logic                 sof_p0;
  logic                 border_p0;
  logic                 edge_p0;
  logic [WORD_SIZE-1:0] thr_s;
  logic [1:0]           mode_s;
  logic [WORD_SIZE-1:0] thr_eff;
  logic [1:0]           mode_eff;
  logic [23:0]          pix_nxt;
  logic [23:0]          pixel_p1;
  logic                 vld_p1;

  assign vis = (hc_visible < 11'(H_ACTIVE)) && (vc_visible < 11'(V_ACTIVE));

  coord_delay #(
    .DEPTH (LATENCY),
    .WIDTH (DLY_W)
  ) u_coord_delay (
    .clock    (clock),
    .reset    (reset),
    .vld      (vis),
    .data     ({hc_visible, vc_visible, pixel_in}),
    .dly_vld  (dvis_p0),
    .dly_data ({dh_p0, dv_p0, dpix_p0})
  );

  // ---- stage p0: delayed tuple aligned with edge_in ----
  assign sof_p0    = dvis_p0 && (dh_p0 == '0) && (dv_p0 == '0);
  assign border_p0 = (dh_p0 < 11'd2) || (dv_p0 < 11'd2);

  // The SOF pixel already uses the freshly sampled controls.
  assign thr_eff  = sof_p0 ? threshold : thr_s;
  assign mode_eff = sof_p0 ? mode : mode_s;
  assign edge_p0  = dvis_p0 && !border_p0 && (edge_in >= thr_eff);

  // frame-stable copies of threshold and mode, captured at SOF
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      thr_s  <= '0;
      mode_s <= '0;
    end else if (sof_p0) begin
      thr_s  <= threshold;
      mode_s <= mode;
    end
  end

  // select the display pixel for the current mode
  always_comb begin
    pix_nxt = '0;
    if (dvis_p0) begin
      case (mode_eff)
        BINARY:  pix_nxt = edge_p0 ? 24'hFFFFFF : 24'h000000;
        OVERLAY: pix_nxt = edge_p0 ? EDGE_COLOR : dpix_p0;
        default: pix_nxt = gray_pix(border_p0 ? '0 : edge_in);
      endcase
    end
  end

  // ---- stage p1: registered output ----
  // output register, cleared on reset so the display sees black
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pixel_p1 <= '0;
      vld_p1   <= 1'b0;
    end else begin
      pixel_p1 <= pix_nxt;
      vld_p1   <= dvis_p0;
    end
  end

  assign pixel_out   = pixel_p1;
  assign pixel_valid = vld_p1;

`ifdef SOBEL_EDGE_COUNT_EN
  localparam int CNT_W = $clog2(H_ACTIVE * V_ACTIVE + 1);

  cnt_state_t       state;
  cnt_state_t       state_nxt;
  logic [CNT_W-1:0] acc;
  logic [CNT_W-1:0] flag_w;
  logic             last_p0;

  assign flag_w  = CNT_W'(edge_p0);
  assign last_p0 = dvis_p0 && (dh_p0 == 11'(H_ACTIVE - 1)) && (dv_p0 == 11'(V_ACTIVE - 1));

  // counter state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= WAIT_SOF;
    else        state <= state_nxt;
  end

  // frame tracking: a repeated SOF restarts the frame without a report
  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_SOF: if (sof_p0) state_nxt = ACTIVE;
      ACTIVE:   if (!sof_p0 && last_p0) state_nxt = EOF;
      // a back-to-back SOF is not lost when there is no blanking
      EOF:      state_nxt = sof_p0 ? ACTIVE : WAIT_SOF;
      default:  state_nxt = WAIT_SOF;
    endcase
  end

  // report pulse for the cycle after the last active pixel
  always_comb begin
    count_valid = (state == EOF);
  end

  // accumulate edge flags; the total is captured as the frame closes so it
  // is already stable while count_valid pulses
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc        <= '0;
      edge_count <= '0;
    end else begin
      case (state)
        WAIT_SOF: if (sof_p0) acc <= flag_w;
        ACTIVE: begin
          if (sof_p0)       acc <= flag_w;
          else if (dvis_p0) acc <= acc + flag_w;
          if (!sof_p0 && last_p0) edge_count <= acc + flag_w;
        end
        EOF:     acc <= sof_p0 ? flag_w : '0;
        default: acc <= '0;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_sobel_post.sv
// Randomized bench for sobel_post with a frame-level reference model.
module tb_sobel_post;

  localparam int          WS = 8;
  localparam int          H  = 16;
  localparam int          V  = 12;
  localparam int          L  = 3;
  localparam logic [23:0] EC = 24'hFF0000;
  localparam int          CW = $clog2(H * V + 1);

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [10:0]   hc_visible = '0;
  logic [10:0]   vc_visible = '0;
  logic [23:0]   pixel_in = '0;
  logic [WS-1:0] edge_in = '0;
  logic [WS-1:0] threshold = '0;
  logic [1:0]    mode = '0;
  logic [23:0]   pixel_out;
  logic          pixel_valid;
`ifdef SOBEL_EDGE_COUNT_EN
  logic [CW-1:0] edge_count;
  logic          count_valid;
`endif

  sobel_post #(
    .WORD_SIZE  (WS),
    .H_ACTIVE   (H),
    .V_ACTIVE   (V),
    .LATENCY    (L),
    .EDGE_COLOR (EC)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .hc_visible  (hc_visible),
    .vc_visible  (vc_visible),
    .pixel_in    (pixel_in),
    .edge_in     (edge_in),
    .threshold   (threshold),
    .mode        (mode),
    .pixel_out   (pixel_out),
    .pixel_valid (pixel_valid)
`ifdef SOBEL_EDGE_COUNT_EN
    ,
    .edge_count  (edge_count),
    .count_valid (count_valid)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          vis;
    int          h;
    int          v;
    logic [23:0] pix;
  } tup_t;

  tup_t hist[$];
  int   sh_thr, sh_mode, acc, rep;
  bit   counting;
  int   n_checks = 0;
  int   n_errors = 0;
  int   pulses = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    tup_t z;
    z.vis = 1'b0; z.h = 0; z.v = 0; z.pix = '0;
    hist.delete();
    for (int i = 0; i < L; i++) hist.push_back(z);
    sh_thr = 0; sh_mode = 0; acc = 0; rep = 0; counting = 1'b0;
  endtask

  // One cycle: apply inputs, predict the registered result, then check it.
  task automatic drive(input int hc, input int vc, input logic [23:0] pix,
                       input int edg, input int thr, input int md);
    tup_t        nw, d;
    logic [23:0] ep;
    logic [7:0]  g;
    bit          ev, ecv, sof, bord, e;
    hc_visible = 11'(hc); vc_visible = 11'(vc); pixel_in = pix;
    edge_in = WS'(edg); threshold = WS'(thr); mode = 2'(md);
    nw.vis = (hc < H) && (vc < V); nw.h = hc; nw.v = vc; nw.pix = pix;
    hist.push_back(nw);
    d = hist.pop_front();
    ep = '0; ev = d.vis; ecv = 1'b0;
    if (d.vis) begin
      sof = (d.h == 0) && (d.v == 0);
      if (sof) begin sh_thr = thr; sh_mode = md; end
      bord = (d.h < 2) || (d.v < 2);
      e = !bord && (edg >= sh_thr);
      case (sh_mode)
        1: ep = e ? 24'hFFFFFF : 24'h0;
        2: ep = e ? EC : d.pix;
        default: begin g = bord ? 8'h0 : 8'(edg); ep = {g, g, g}; end
      endcase
      if (sof) begin counting = 1'b1; acc = 0; end
      if (counting) acc += int'(e);
      if (counting && d.h == H - 1 && d.v == V - 1) begin
        ecv = 1'b1; rep = acc; counting = 1'b0; acc = 0;
      end
    end
    @(posedge clock); #1;
    check_val("pixel_out", pixel_out, ep);
    check_val("pixel_valid", pixel_valid, ev);
`ifdef SOBEL_EDGE_COUNT_EN
    if (count_valid === 1'b1) pulses++;
    check_val("count_valid", count_valid, ecv);
    check_val("edge_count", edge_count, rep);
`endif
  endtask

  // Present one coordinate, then feed its magnitude L cycles later.
  task automatic probe(input int h, input int v, input logic [23:0] pix,
                       input int edg, input int thr, input int md);
    drive(h, v, pix, 0, thr, md);
    for (int i = 1; i < L; i++) drive(600, 600, 24'h0, 0, thr, md);
    drive(600, 600, 24'h0, edg, thr, md);
  endtask

  // Raster a frame with 4 blank columns per line; rows includes blank rows.
  task automatic run_frame(input int rows, input int kind, input int thr,
                           input int md, input bit rnd_ctl);
    for (int v = 0; v < rows; v++) begin
      for (int h = 0; h < H + 4; h++) begin
        tup_t d;
        int   edg, t, m;
        d = hist[0];
        t = thr; m = md;
        case (kind)
          0: edg = int'($urandom_range(0, 255));
          1: edg = 255;
          2: edg = 0;
          default: edg = (d.vis && d.v == 2 && d.h >= 2 && d.h < 12) ? 255 : 0;
        endcase
        if (rnd_ctl) begin
          t = int'($urandom_range(0, 255));
          m = int'($urandom_range(0, 3));
        end
        drive(h, v, 24'($urandom), edg, t, m);
      end
    end
  endtask

  // Asynchronous assert mid-cycle, synchronous release.
  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    check_val("rst_pixel_out", pixel_out, 24'h0);
    check_val("rst_pixel_valid", pixel_valid, 1'b0);
`ifdef SOBEL_EDGE_COUNT_EN
    check_val("rst_edge_count", edge_count, 0);
    check_val("rst_count_valid", count_valid, 1'b0);
`endif
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    #12;
    check_val("init_pixel_out", pixel_out, 24'h0);
    check_val("init_pixel_valid", pixel_valid, 1'b0);
    @(posedge clock); #1 reset = 1'b1;

    // gray interior pixel, then async reset while the output is non-zero
    probe(5, 5, 24'hABCDEF, 77, 0, 0);
    check_val("gray_interior", pixel_out, 24'h4D4D4D);
    check_val("first_valid", pixel_valid, 1'b1);
    do_reset();
    probe(1, 7, 24'hABCDEF, 200, 0, 0);
    check_val("gray_border", pixel_out, 24'h0);

    // binary mode with threshold 100; mid-frame change waits for next SOF
    probe(0, 0, 24'h0, 0, 100, 1);
    probe(5, 5, 24'h0, 99, 100, 1);
    check_val("bin_below", pixel_out, 24'h0);
    probe(5, 6, 24'h0, 100, 100, 1);
    check_val("bin_at_thr", pixel_out, 24'hFFFFFF);
    probe(6, 6, 24'h0, 150, 200, 1);
    check_val("bin_midframe_thr", pixel_out, 24'hFFFFFF);
    probe(0, 0, 24'h0, 0, 200, 1);
    probe(6, 6, 24'h0, 150, 200, 1);
    check_val("bin_new_thr", pixel_out, 24'h0);

    // overlay mode
    probe(0, 0, 24'h0, 0, 100, 2);
    probe(5, 5, 24'h123456, 50, 100, 2);
    check_val("ovl_below", pixel_out, 24'h123456);
    probe(5, 5, 24'h123456, 200, 100, 2);
    check_val("ovl_above", pixel_out, EC);
    probe(600, 5, 24'h123456, 200, 100, 2);
    check_val("ovl_offscreen_pix", pixel_out, 24'h0);
    check_val("ovl_offscreen_vld", pixel_valid, 1'b0);

    // random frames with controls changing every cycle
    for (int f = 0; f < 3; f++) run_frame(V + 2, 0, 0, 0, 1'b1);

    // counting scenarios (pixel path checked in every build)
    pulses = 0;
    run_frame(V + 2, 1, 1, 1, 1'b0);
`ifdef SOBEL_EDGE_COUNT_EN
    check_val("cnt_full", edge_count, (H - 2) * (V - 2));
    check_val("cnt_full_pulses", pulses, 1);
`endif
    pulses = 0;
    run_frame(V + 2, 2, 1, 1, 1'b0);
`ifdef SOBEL_EDGE_COUNT_EN
    check_val("cnt_zero", edge_count, 0);
    check_val("cnt_zero_pulses", pulses, 1);
`endif
    pulses = 0;
    run_frame(7, 1, 1, 2, 1'b0);
    run_frame(V + 2, 3, 1, 2, 1'b0);
`ifdef SOBEL_EDGE_COUNT_EN
    check_val("cnt_trunc", edge_count, 10);
    check_val("cnt_trunc_pulses", pulses, 1);
`endif
    do_reset();
    run_frame(V + 2, 0, 0, 0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
